mem_prefetch_pingpong: RTL
==========================

// Module: mem_prefetch_pingpong
// PURPOSE
//  Next-generation memory module for the Conv1D datapath: a backing SRAM plus a ping-pong L0 buffer (two banks).
//  An internal burst FSM copies Burst_Len words from the SRAM into the free L0 bank.
//  The PE array consumes the other bank with no stall.
//  One instance is used per operand stream (weight, input, output); Para_Deg sets the word width.
// PARAMETERS
//  Data_Width       8                   bits per element
//  Para_Deg         1                   elements per word; word width W = Para_Deg*Data_Width
//  Mem_Addr_Width   4                   backing SRAM address bits
//  Mem_Depth        1<<Mem_Addr_Width   backing SRAM words
//  Bank_Addr_Width  2                   L0 bank address bits
//  Burst_Len        1<<Bank_Addr_Width  words per fetch; one fetch fills one whole bank
// PORTS
//  clk          in   1                clock
//  Mem_Reset    in   1                synchronous, active-high reset
//  Host_En_W    in   1                backing SRAM write strobe
//  Host_Addr_W  in   Mem_Addr_Width   backing SRAM write address
//  Host_Data_W  in   W                backing SRAM write data
//  Host_Ready   out  1                1 = host write accepted this cycle
//  Fetch_Req    in   1                request burst starting at Fetch_Base
//  Fetch_Base   in   Mem_Addr_Width   burst start address
//  Fetch_Ready  out  1                request accepted when Fetch_Req && Fetch_Ready
//  Fetch_Busy   out  1                burst in flight
//  Fetch_Done   out  1                one-cycle pulse when a bank becomes valid
//  Rd_Valid     out  1                current read bank holds a complete burst
//  L0_En_R      in   1                consumer read strobe
//  L0_Addr_R    in   Bank_Addr_Width  word index within current read bank
//  L0_Data_R    out  W                read data, registered
//  Bank_Release in   1                consumer finished current bank
// BEHAVIOUR
//  Reset (Mem_Reset high at a clk edge):
//   - state=IDLE; fill_ptr=rd_ptr=0; bank_valid=2'b00; burst counters=0.
//   - L0_Data_R=0; Fetch_Done=0; Fetch_Busy=0.
//   - Memory contents are not cleared.
//   - Reset mid-burst aborts the burst: no Done, bank stays invalid.
//  FSM states:
//   - IDLE -> READ on accept.
//   - READ issues SRAM reads for Burst_Len cycles, then -> DRAIN.
//   - DRAIN writes the last word, sets bank_valid[fill_ptr], toggles fill_ptr, then -> IDLE.
//  Fetch_Ready = (state==IDLE) && !bank_valid[fill_ptr]. Fetch_Base is latched on accept.
//  Timing (accept at edge T):
//   - SRAM read i at cycle T+1+i, address (Fetch_Base+i) mod Mem_Depth; wraps at Mem_Depth.
//   - SRAM read latency is 1 cycle; L0 write i at cycle T+2+i into bank fill_ptr, word i.
//   - Fetch_Done high and Rd_Valid reflects the new bank in cycle T+Burst_Len+2.
//  Fetch_Busy = (state != IDLE).
//  Host_Ready = !Fetch_Busy. A host write with Host_Ready=0 is dropped with no side effect.
//  Rd_Valid = bank_valid[rd_ptr].
//  Consumer read:
//   - L0_En_R && Rd_Valid: L0_Data_R updates next cycle with bank rd_ptr, word L0_Addr_R.
//   - L0_En_R while !Rd_Valid is ignored; L0_Data_R holds its value.
//  Bank_Release:
//   - With Rd_Valid: clears bank_valid[rd_ptr] and toggles rd_ptr.
//   - Without Rd_Valid: ignored.
//  Simultaneous release (bank rd_ptr) and DRAIN completion (bank fill_ptr != rd_ptr) in the same cycle: both take effect.
//  Fetch_Req while !Fetch_Ready is not queued; the requester holds it.
// STRUCTURE
//  Package conv_mem_pkg:
//   - FSM enum FETCH_IDLE / FETCH_READ / FETCH_DRAIN.
//   - Default widths.
//  Storage:
//   - Backing SRAM is one Dual_SRAM instance (Ram_Depth=Mem_Depth).
//   - L0 is one Dual_SRAM instance of depth 2*Burst_Len, addressed {bank, word}.
//  Sub-module pingpong_fetch_fsm holds state, counters, pointers and bank_valid.
//  The top level contains only the two Dual_SRAM instances and glue.
// TESTING
//  1. Host writes 0x10..0x13 @0..3; Fetch base 0 accepted at T.
//     -> Busy T+1..T+5; Done at T+6; L0 reads 0..3 return 0x10..0x13.
//  2. Mem holds 0xA0+a at address a; Fetch base 14 (Mem_Depth 16).
//     -> L0 words = 0xAE,0xAF,0xA0,0xA1 (address wrap).
//  3. Two back-to-back fetches (bases 0 and 4) with no release.
//     -> both banks valid; Fetch_Ready=0; a third Req stalls until Bank_Release, then is accepted next IDLE cycle.
//  4. Bank_Release asserted in the same cycle as the second burst's DRAIN.
//     -> rd_ptr=1, bank 1 valid, bank 0 invalid, Fetch_Ready=1 next cycle.
//  5. Mem_Reset at 2nd READ cycle.
//     -> next cycle IDLE, Rd_Valid=0, L0_Data_R=0, no Done pulse.
//     -> a new fetch then completes normally.
//  6. Host write 0xFF @2 during Busy (dropped, Host_Ready=0).
//     -> a later fetch base 0 reads the old value at word 2.

Source files
------------

// File: rtl/conv_mem_pkg.sv
// rtl/conv_mem_pkg.sv - shared widths and burst FSM states for the ping-pong operand memory
package conv_mem_pkg;

   localparam int DefDataWidth     = 8;
   localparam int DefParaDeg       = 1;
   localparam int DefMemAddrWidth  = 4;
   localparam int DefBankAddrWidth = 2;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_READ  = 2'd1,
      FETCH_DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/Dual_SRAM.sv
// rtl/Dual_SRAM.sv - simple dual-port RAM, one write port and one registered read port
module Dual_SRAM #(
   parameter int Ram_Width      = 8,
   parameter int Ram_Depth      = 16,
   parameter int Ram_Addr_Width = $clog2(Ram_Depth)
)(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      wr_en_i,
   input  logic [Ram_Addr_Width-1:0] wr_addr_i,
   input  logic [Ram_Width-1:0]      wr_data_i,
   input  logic                      rd_en_i,
   input  logic [Ram_Addr_Width-1:0] rd_addr_i,
   output logic [Ram_Width-1:0]      rd_data_o
);

   logic [Ram_Width-1:0] mem_q [Ram_Depth];
   logic [Ram_Width-1:0] rd_data_q;

   // Array contents are never reset; only the output register is.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pingpong_fetch_fsm.sv
// rtl/pingpong_fetch_fsm.sv - burst fetch FSM, bank pointers and bank-valid tracking
module pingpong_fetch_fsm
   import conv_mem_pkg::*;
#(
   parameter int Mem_Addr_Width  = DefMemAddrWidth,
   parameter int Bank_Addr_Width = DefBankAddrWidth
)(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      fetch_req_i,
   input  logic [Mem_Addr_Width-1:0] fetch_base_i,
   input  logic                      bank_release_i,
   output logic                      fetch_ready_o,
   output logic                      fetch_busy_o,
   output logic                      fetch_done_o,
   output logic                      rd_valid_o,
   output logic                      rd_bank_o,
   output logic                      sram_rd_en_o,
   output logic [Mem_Addr_Width-1:0] sram_rd_addr_o,
   output logic                      l0_wr_en_o,
   output logic [Bank_Addr_Width:0]  l0_wr_addr_o
);

   localparam logic [Bank_Addr_Width-1:0] LastWord = '1;

   fetch_state_e                state_q, state_d;
   logic [Bank_Addr_Width-1:0]  cnt_q, cnt_d;
   logic [Mem_Addr_Width-1:0]   base_q, base_d;
   logic                        fill_ptr_q, fill_ptr_d;
   logic                        rd_ptr_q, rd_ptr_d;
   logic [1:0]                  bank_valid_q, bank_valid_d;
   logic                        done_q, done_d;
   logic                        wr_en_q, wr_en_d;
   logic [Bank_Addr_Width-1:0]  wr_word_q, wr_word_d;

   assign fetch_ready_o  = (state_q == FETCH_IDLE) && !bank_valid_q[fill_ptr_q];
   assign fetch_busy_o   = (state_q != FETCH_IDLE);
   assign fetch_done_o   = done_q;
   assign rd_valid_o     = bank_valid_q[rd_ptr_q];
   assign rd_bank_o      = rd_ptr_q;
   assign sram_rd_en_o   = (state_q == FETCH_READ);
   assign sram_rd_addr_o = base_q + Mem_Addr_Width'(cnt_q);
   assign l0_wr_en_o     = wr_en_q;
   assign l0_wr_addr_o   = {fill_ptr_q, wr_word_q};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      base_d       = base_q;
      fill_ptr_d   = fill_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      bank_valid_d = bank_valid_q;
      done_d       = 1'b0;
      wr_en_d      = 1'b0;
      wr_word_d    = cnt_q;

      case (state_q)
         FETCH_IDLE: begin
            if (fetch_req_i && fetch_ready_o) begin
               base_d  = fetch_base_i;
               cnt_d   = '0;
               state_d = FETCH_READ;
            end
         end
         FETCH_READ: begin
            // The SRAM word read now lands in L0 one cycle later.
            wr_en_d = 1'b1;
            if (cnt_q == LastWord) begin
               cnt_d   = '0;
               state_d = FETCH_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FETCH_DRAIN: begin
            bank_valid_d[fill_ptr_q] = 1'b1;
            fill_ptr_d               = ~fill_ptr_q;
            done_d                   = 1'b1;
            state_d                  = FETCH_IDLE;
         end
         default: state_d = FETCH_IDLE;
      endcase

      // A burst never targets a valid bank, so this cannot undo the DRAIN set above.
      if (bank_release_i && bank_valid_q[rd_ptr_q]) begin
         bank_valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d               = ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= FETCH_IDLE;
         cnt_q        <= '0;
         base_q       <= '0;
         fill_ptr_q   <= 1'b0;
         rd_ptr_q     <= 1'b0;
         bank_valid_q <= 2'b00;
         done_q       <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_word_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         fill_ptr_q   <= fill_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         bank_valid_q <= bank_valid_d;
         done_q       <= done_d;
         wr_en_q      <= wr_en_d;
         wr_word_q    <= wr_word_d;
      end
   end

endmodule

// File: rtl/mem_prefetch_pingpong.sv
// rtl/mem_prefetch_pingpong.sv - backing SRAM plus ping-pong L0 buffer fed by a burst prefetcher
module mem_prefetch_pingpong
   import conv_mem_pkg::*;
#(
   parameter int Data_Width      = DefDataWidth,
   parameter int Para_Deg        = DefParaDeg,
   parameter int Mem_Addr_Width  = DefMemAddrWidth,
   parameter int Mem_Depth       = 1 << Mem_Addr_Width,
   parameter int Bank_Addr_Width = DefBankAddrWidth,
   parameter int Burst_Len       = 1 << Bank_Addr_Width
)(
   input  logic                           clk,
   input  logic                           Mem_Reset,
   input  logic                           Host_En_W,
   input  logic [Mem_Addr_Width-1:0]      Host_Addr_W,
   input  logic [Para_Deg*Data_Width-1:0] Host_Data_W,
   output logic                           Host_Ready,
   input  logic                           Fetch_Req,
   input  logic [Mem_Addr_Width-1:0]      Fetch_Base,
   output logic                           Fetch_Ready,
   output logic                           Fetch_Busy,
   output logic                           Fetch_Done,
   output logic                           Rd_Valid,
   input  logic                           L0_En_R,
   input  logic [Bank_Addr_Width-1:0]     L0_Addr_R,
   output logic [Para_Deg*Data_Width-1:0] L0_Data_R,
   input  logic                           Bank_Release
);

   localparam int W = Para_Deg * Data_Width;

   logic                      sram_rd_en;
   logic [Mem_Addr_Width-1:0] sram_rd_addr;
   logic [W-1:0]              sram_rd_data;
   logic                      l0_wr_en;
   logic [Bank_Addr_Width:0]  l0_wr_addr;
   logic                      rd_bank;

   assign Host_Ready = !Fetch_Busy;

   pingpong_fetch_fsm #(
      .Mem_Addr_Width  (Mem_Addr_Width),
      .Bank_Addr_Width (Bank_Addr_Width)
   ) u_fsm (
      .clk_i          (clk),
      .rst_i          (Mem_Reset),
      .fetch_req_i    (Fetch_Req),
      .fetch_base_i   (Fetch_Base),
      .bank_release_i (Bank_Release),
      .fetch_ready_o  (Fetch_Ready),
      .fetch_busy_o   (Fetch_Busy),
      .fetch_done_o   (Fetch_Done),
      .rd_valid_o     (Rd_Valid),
      .rd_bank_o      (rd_bank),
      .sram_rd_en_o   (sram_rd_en),
      .sram_rd_addr_o (sram_rd_addr),
      .l0_wr_en_o     (l0_wr_en),
      .l0_wr_addr_o   (l0_wr_addr)
   );

   Dual_SRAM #(
      .Ram_Width      (W),
      .Ram_Depth      (Mem_Depth),
      .Ram_Addr_Width (Mem_Addr_Width)
   ) u_backing (
      .clk_i     (clk),
      .rst_i     (Mem_Reset),
      .wr_en_i   (Host_En_W && Host_Ready),
      .wr_addr_i (Host_Addr_W),
      .wr_data_i (Host_Data_W),
      .rd_en_i   (sram_rd_en),
      .rd_addr_i (sram_rd_addr),
      .rd_data_o (sram_rd_data)
   );

   // L0 word address is {bank, word}; the consumer only ever sees bank rd_bank.
   Dual_SRAM #(
      .Ram_Width      (W),
      .Ram_Depth      (2 * Burst_Len),
      .Ram_Addr_Width (Bank_Addr_Width + 1)
   ) u_l0 (
      .clk_i     (clk),
      .rst_i     (Mem_Reset),
      .wr_en_i   (l0_wr_en),
      .wr_addr_i (l0_wr_addr),
      .wr_data_i (sram_rd_data),
      .rd_en_i   (L0_En_R && Rd_Valid),
      .rd_addr_i ({rd_bank, L0_Addr_R}),
      .rd_data_o (L0_Data_R)
   );

endmodule
